// File: rtl/con_ff_unit_if.sv
// Condition-unit bus interface.
// Groups the operand bus, the condition code, the start/operand-B/clear controls
// and the CON result outputs.
//   master : drives bus, ir_cond, con_start, con_two, opb_valid, con_clear;
//            observes con_out, con_valid, busy, taken_count.
//   slave  : the condition unit itself (mirror of master).
interface con_ff_unit_if #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned CNT_W = 8
) ();
  logic [BITS-1:0]  bus;
  logic [2:0]       ir_cond;
  logic             con_start;
  logic             con_two;
  logic             opb_valid;
  logic             con_clear;
  logic             con_out;
  logic             con_valid;
  logic             busy;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output bus, ir_cond, con_start, con_two, opb_valid, con_clear,
    input  con_out, con_valid, busy, taken_count
  );

  modport slave (
    input  bus, ir_cond, con_start, con_two, opb_valid, con_clear,
    output con_out, con_valid, busy, taken_count
  );
endinterface

// File: rtl/con_ff_unit.sv
// CON flip-flop unit: evaluates a branch condition from the data bus and
// registers the result for the control unit.
//   Single-operand mode : bus versus zero, result one cycle after con_start.
//   Two-operand mode    : A captured at con_start, compared with the bus in the
//                         cycle opb_valid is high (mode latched from ir_cond).
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   clr  - synchronous active-high reset, overrides every other input
//   cif  - con_ff_unit_if slave: bus, ir_cond, con_start, con_two, opb_valid,
//          con_clear in; con_out, con_valid, busy, taken_count out
module con_ff_unit #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned CNT_W = 8
) (
  input logic          clk,
  input logic          clr,
  con_ff_unit_if.slave cif
);

  typedef enum logic [0:0] {StIdle, StWaitB} state_e;

  state_e           state_q, state_d;
  logic [BITS-1:0]  a_q, a_d;
  logic [2:0]       mode_q, mode_d;
  logic             con_out_q, con_out_d;
  logic             con_valid_q, con_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic single_res;
  logic two_res;
  logic bus_zero;
  logic bus_neg;
  logic ab_eq;
  logic ab_slt;
  logic ab_ult;

  assign bus_zero = (cif.bus == '0);
  assign bus_neg  = cif.bus[BITS-1];
  assign ab_eq    = (a_q == cif.bus);
  // Full-width compares; no subtract-and-test-sign, so no overflow artefacts.
  assign ab_slt   = ($signed(a_q) < $signed(cif.bus));
  assign ab_ult   = (a_q < cif.bus);

  always_comb begin
    single_res = 1'b0;
    unique case (cif.ir_cond)
      3'b000:  single_res = bus_zero;
      3'b001:  single_res = !bus_zero;
      3'b010:  single_res = !bus_neg;
      3'b011:  single_res = bus_neg;
      3'b100:  single_res = !bus_neg && !bus_zero;
      3'b101:  single_res = bus_neg || bus_zero;
      3'b110:  single_res = 1'b1;
      default: single_res = 1'b0;
    endcase
  end

  // Uses the latched mode; ir_cond is ignored while waiting for operand B.
  always_comb begin
    two_res = 1'b0;
    unique case (mode_q)
      3'b000:  two_res = ab_eq;
      3'b001:  two_res = !ab_eq;
      3'b010:  two_res = !ab_slt;
      3'b011:  two_res = ab_slt;
      3'b100:  two_res = !ab_slt && !ab_eq;
      3'b101:  two_res = ab_slt || ab_eq;
      3'b110:  two_res = !ab_ult;
      default: two_res = ab_ult;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    mode_d      = mode_q;
    con_out_d   = con_out_q;
    con_valid_d = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cif.con_start && !cif.con_two) begin
          // Evaluation wins over a same-cycle con_clear.
          con_out_d   = single_res;
          con_valid_d = 1'b1;
          if (single_res && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        end else if (cif.con_start && cif.con_two) begin
          a_d     = cif.bus;
          mode_d  = cif.ir_cond;
          state_d = StWaitB;
          if (cif.con_clear) con_out_d = 1'b0;
        end else if (cif.con_clear) begin
          con_out_d = 1'b0;
        end
      end
      StWaitB: begin
        // Abort wins over a same-cycle operand B; con_start is ignored here.
        if (cif.con_clear) begin
          con_out_d = 1'b0;
          state_d   = StIdle;
        end else if (cif.opb_valid) begin
          con_out_d   = two_res;
          con_valid_d = 1'b1;
          state_d     = StIdle;
          if (two_res && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      a_q         <= '0;
      mode_q      <= '0;
      con_out_q   <= 1'b0;
      con_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      mode_q      <= mode_d;
      con_out_q   <= con_out_d;
      con_valid_q <= con_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cif.con_out     = con_out_q;
  assign cif.con_valid   = con_valid_q;
  assign cif.busy        = (state_q == StWaitB);
  assign cif.taken_count = cnt_q;

endmodule
